// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv
// Description : Iterative RV32M multiply/divide unit for the execute stage.
//               Shift-add multiply and restoring divide, one bit per cycle,
//               with a busy/done handshake and single-cycle fast paths for
//               divide-by-zero and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] c_MUL    = 3'b000;
    localparam logic [2:0] c_MULH   = 3'b001;
    localparam logic [2:0] c_MULHSU = 3'b010;
    localparam logic [2:0] c_DIV    = 3'b100;
    localparam logic [2:0] c_REM    = 3'b110;
    localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ONES    = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [4:0]          r_cnt;
    logic [2:0]          r_op;
    logic                r_neg;      // product / quotient sign
    logic                r_sign_a;   // remainder sign
    logic [XLEN-1:0]     r_opnd;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0]   r_acc;      // {hi, lo}: product register or {remainder, quotient}
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_res;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_trial;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    // Operand decode at issue: signedness, magnitudes and fast-path detection
    always_comb begin
        w_a_signed = (funct3 == c_MULH) || (funct3 == c_MULHSU) ||
                     (funct3 == c_DIV)  || (funct3 == c_REM);
        w_b_signed = (funct3 == c_MULH) || (funct3 == c_DIV) || (funct3 == c_REM);
        w_sign_a   = w_a_signed && op_a[XLEN-1];
        w_sign_b   = w_b_signed && op_b[XLEN-1];
        w_mag_a    = w_sign_a ? -op_a : op_a;
        w_mag_b    = w_sign_b ? -op_b : op_b;
        // funct3[2] selects divide family, funct3[1] selects remainder,
        // funct3[0] clear means signed divide
        w_fast     = funct3[2] && ((op_b == '0) ||
                     (!funct3[0] && (op_a == c_MIN_NEG) && (op_b == c_ONES)));
        if (op_b == '0)
            w_fast_res = funct3[1] ? op_a : c_ONES;
        else
            w_fast_res = funct3[1] ? '0 : c_MIN_NEG;
    end

    // One iteration step plus sign fix-up and result selection
    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, shifted out LSB first
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        // Divide: trial subtract of the divisor from the left-shifted partial remainder
        w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
        if (r_op[2]) begin
            if (w_div_trial[XLEN])
                w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
            else
                w_acc_next = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        end
        w_prod = r_neg ? -w_acc_next : w_acc_next;
        w_quo  = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
        w_rem  = r_sign_a ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
        case (r_op)
            c_MUL:         w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:        w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: w_final = w_quo;
            default:       w_final = w_rem;
        endcase
    end

    // Control FSM with registered busy/done/result and the iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_sign_a <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !flush) begin
                        r_op     <= funct3;
                        r_neg    <= w_sign_a ^ w_sign_b;
                        r_sign_a <= w_sign_a;
                        r_busy   <= 1'b1;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            // Divide keeps the dividend in the low half; multiply keeps the multiplier there
                            r_opnd  <= funct3[2] ? w_mag_b : w_mag_a;
                            r_acc   <= {{XLEN{1'b0}}, funct3[2] ? w_mag_a : w_mag_b};
                            r_cnt   <= 5'd31;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == 5'd0) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire
